// File: rtl/ddr_burst_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the two-client DDR burst arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE, GRANT_WR, GRANT_RD, GAP)
//   - GNT_WR/GNT_RD : one-hot grant codes (bit0 = write, bit1 = read)
//   - GAP_LEN     : idle cycles inserted after every burst before the next
//                   arbitration decision
// Optional feature macro used by the arbiter: ARB_ROUND_ROBIN_EN.
// ----------------------------------------------------------------------------
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_WR = 2'd1,
        GRANT_RD = 2'd2,
        GAP      = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_WR   = 2'b01;
    localparam logic [1:0] GNT_RD   = 2'b10;

    localparam int         GAP_LEN   = 1;
    localparam int         GAP_CNT_W = 2;
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_LEN - 1);

endpackage

// File: rtl/ddr_burst_arbiter_arb_pick.sv
// ----------------------------------------------------------------------------
// arb_pick
// Two-way winner select for the DDR burst arbiter. Purely combinational.
// Ports:
//   init_done_i : memory calibrated; no winner while low
//   wr_req_i    : write client request
//   rd_req_i    : read client request
//   rr_ptr_i    : round-robin pointer, 1 = read favoured (write served last)
//   pick_o      : one-hot winner (GNT_WR / GNT_RD), GNT_NONE if nobody
// Configuration macro ARB_ROUND_ROBIN_EN:
//   defined   - on contention the client not served last wins
//   undefined - fixed priority, read wins so the display path never starves
// ----------------------------------------------------------------------------
module arb_pick
    import ddr_arb_pkg::*;
(
    input  logic       init_done_i,
    input  logic       wr_req_i,
    input  logic       rd_req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] pick_o
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the pointer; it is kept on the port so the
    // parent is identical in both builds.
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr_i;
`endif

    always_comb begin
        pick_o = GNT_NONE;
        if (init_done_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (wr_req_i && rd_req_i) begin
                pick_o = rr_ptr_i ? GNT_RD : GNT_WR;
            end else if (wr_req_i) begin
                pick_o = GNT_WR;
            end else if (rd_req_i) begin
                pick_o = GNT_RD;
            end
`else
            if (rd_req_i) begin
                pick_o = GNT_RD;
            end else if (wr_req_i) begin
                pick_o = GNT_WR;
            end
`endif
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_burst_arbiter
// Shares the single ddr_ctrl burst interface between the camera write client
// and the LCD read client (phy_clk domain). One burst is outstanding at a
// time; the granted client's len/addr are latched at grant and held stable
// on the memory side for the whole burst.
// Ports:
//   mem_clk, rst          : phy_clk, synchronous active-high reset
//   init_done             : no new grant while low (running burst completes)
//   wr_req/wr_len/wr_addr : write client request, held until wr_finish
//   wr_data_req/wr_data   : write data strobe (gated) / write data
//   wr_finish             : one-cycle write completion pulse
//   rd_req/rd_len/rd_addr : read client request, held until rd_finish
//   rd_data_valid/rd_data : read data valid (gated) / read data (broadcast)
//   rd_finish             : one-cycle read completion pulse
//   m_wr_* / m_rd_*       : memory-side burst interface
//   busy                  : a burst is in flight
//   grant                 : one-hot owner, bit0 = write, bit1 = read
// Configuration macro ARB_ROUND_ROBIN_EN selects round-robin instead of
// read-priority arbitration (implemented in arb_pick).
// ----------------------------------------------------------------------------
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  init_done,

    input  logic                  wr_req,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_data_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_finish,

    input  logic                  rd_req,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_finish,

    output logic                  m_wr_req,
    output logic [LEN_WIDTH-1:0]  m_wr_len,
    output logic [ADDR_WIDTH-1:0] m_wr_addr,
    output logic [DATA_WIDTH-1:0] m_wr_data,
    input  logic                  m_wr_data_req,
    input  logic                  m_wr_finish,

    output logic                  m_rd_req,
    output logic [LEN_WIDTH-1:0]  m_rd_len,
    output logic [ADDR_WIDTH-1:0] m_rd_addr,
    input  logic                  m_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] m_rd_data,
    input  logic                  m_rd_finish,

    output logic                  busy,
    output logic [1:0]            grant
);

    arb_state_e            state_q;
    logic [1:0]            grant_q;
    logic                  busy_q;
    logic                  zero_q;      // current grant is a zero-length burst
    logic                  rr_q;        // 1: write was served last, favour read
    logic                  m_wr_req_q;
    logic                  m_rd_req_q;
    logic [LEN_WIDTH-1:0]  wr_len_q;
    logic [LEN_WIDTH-1:0]  rd_len_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [GAP_CNT_W-1:0]  gap_cnt_q;

    logic [1:0]            pick;
    logic                  wr_done;
    logic                  rd_done;

    arb_pick u_pick (
        .init_done_i (init_done),
        .wr_req_i    (wr_req),
        .rd_req_i    (rd_req),
        .rr_ptr_i    (rr_q),
        .pick_o      (pick)
    );

    // Completion is only recognised in the owning GRANT state, so stray or
    // cross-direction finish strobes never reach a client. A zero-length
    // grant completes on its own in the cycle after selection.
    assign wr_done = (state_q == GRANT_WR) && (zero_q || m_wr_finish);
    assign rd_done = (state_q == GRANT_RD) && (zero_q || m_rd_finish);

    assign wr_finish     = wr_done;
    assign rd_finish     = rd_done;
    assign wr_data_req   = m_wr_data_req   && grant_q[0] && !zero_q;
    assign rd_data_valid = m_rd_data_valid && grant_q[1] && !zero_q;

    assign m_wr_data = wr_data;
    assign rd_data   = m_rd_data;

    assign m_wr_req  = m_wr_req_q;
    assign m_wr_len  = wr_len_q;
    assign m_wr_addr = wr_addr_q;
    assign m_rd_req  = m_rd_req_q;
    assign m_rd_len  = rd_len_q;
    assign m_rd_addr = rd_addr_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= GNT_NONE;
            busy_q     <= 1'b0;
            zero_q     <= 1'b0;
            rr_q       <= 1'b0;
            m_wr_req_q <= 1'b0;
            m_rd_req_q <= 1'b0;
            wr_len_q   <= '0;
            rd_len_q   <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick != GNT_NONE) begin
                        grant_q <= pick;
                        busy_q  <= 1'b1;
                        rr_q    <= pick[0];
                        if (pick[0]) begin
                            wr_len_q   <= wr_len;
                            wr_addr_q  <= wr_addr;
                            zero_q     <= (wr_len == '0);
                            m_wr_req_q <= (wr_len != '0);
                            state_q    <= GRANT_WR;
                        end else begin
                            rd_len_q   <= rd_len;
                            rd_addr_q  <= rd_addr;
                            zero_q     <= (rd_len == '0);
                            m_rd_req_q <= (rd_len != '0);
                            state_q    <= GRANT_RD;
                        end
                    end
                end
                GRANT_WR: begin
                    if (wr_done) begin
                        m_wr_req_q <= 1'b0;
                        grant_q    <= GNT_NONE;
                        busy_q     <= 1'b0;
                        zero_q     <= 1'b0;
                        gap_cnt_q  <= '0;
                        state_q    <= GAP;
                    end
                end
                GRANT_RD: begin
                    if (rd_done) begin
                        m_rd_req_q <= 1'b0;
                        grant_q    <= GNT_NONE;
                        busy_q     <= 1'b0;
                        zero_q     <= 1'b0;
                        gap_cnt_q  <= '0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    // Gives the finished client time to drop its request
                    // before the next decision.
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for ddr_burst_arbiter: directed stimulus, a small ddr_ctrl burst
// model, and a scoreboard monitor that compares every memory request and
// every client finish against queued expectations.
// ----------------------------------------------------------------------------
module tb_ddr_burst_arbiter;

    localparam int DW = 32;
    localparam int AW = 25;
    localparam int LW = 10;

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          wr_req;
    logic [LW-1:0] wr_len;
    logic [AW-1:0] wr_addr;
    logic          wr_data_req;
    logic [DW-1:0] wr_data;
    logic          wr_finish;
    logic          rd_req;
    logic [LW-1:0] rd_len;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          rd_finish;
    logic          m_wr_req;
    logic [LW-1:0] m_wr_len;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic          m_wr_data_req;
    logic          m_wr_finish;
    logic          m_rd_req;
    logic [LW-1:0] m_rd_len;
    logic [AW-1:0] m_rd_addr;
    logic          m_rd_data_valid;
    logic [DW-1:0] m_rd_data;
    logic          m_rd_finish;
    logic          busy;
    logic [1:0]    grant;

    ddr_burst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .mem_clk(mem_clk), .rst(rst), .init_done(init_done),
        .wr_req(wr_req), .wr_len(wr_len), .wr_addr(wr_addr),
        .wr_data_req(wr_data_req), .wr_data(wr_data), .wr_finish(wr_finish),
        .rd_req(rd_req), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_finish(rd_finish),
        .m_wr_req(m_wr_req), .m_wr_len(m_wr_len), .m_wr_addr(m_wr_addr),
        .m_wr_data(m_wr_data), .m_wr_data_req(m_wr_data_req), .m_wr_finish(m_wr_finish),
        .m_rd_req(m_rd_req), .m_rd_len(m_rd_len), .m_rd_addr(m_rd_addr),
        .m_rd_data_valid(m_rd_data_valid), .m_rd_data(m_rd_data), .m_rd_finish(m_rd_finish),
        .busy(busy), .grant(grant)
    );

    always #5 mem_clk = ~mem_clk;

    int cyc = 0;
    always @(posedge mem_clk) cyc <= cyc + 1;

    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            cyc;
    } req_t;

    typedef struct {
        bit rd;
        int beats;
        int cyc;
    } fin_t;

    req_t exp_req[$];
    fin_t exp_fin[$];

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    int last_fin_cyc = 0;
    int wr_beats = 0;
    int rd_beats = 0;
    bit stray_wr = 1'b0;
    bit stray_rd = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mem_clk);
            #3;
        end
    endtask

    task automatic push_req(input bit rd, input logic [AW-1:0] a, input logic [LW-1:0] l, input int c);
        req_t e;
        e.rd = rd; e.addr = a; e.len = l; e.cyc = c;
        exp_req.push_back(e);
    endtask

    task automatic push_fin(input bit rd, input int beats, input int c);
        fin_t e;
        e.rd = rd; e.beats = beats; e.cyc = c;
        exp_fin.push_back(e);
    endtask

    task automatic wait_fin(input int n0, input string nm);
        int k = 0;
        while (fin_cnt == n0 && k < 400) begin
            step(1);
            k++;
        end
        checks++;
        if (fin_cnt == n0) begin
            errors++;
            $display("FAIL %s timeout: no finish within 400 cycles", nm);
        end
    endtask

    task automatic wait_beats(input bit rd, input int n, input string nm);
        int k = 0;
        while ((rd ? rd_beats : wr_beats) < n && k < 200) begin
            step(1);
            k++;
        end
        checks++;
        if ((rd ? rd_beats : wr_beats) < n) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d required=%0d", nm, rd ? rd_beats : wr_beats, n);
        end
    endtask

    // ddr_ctrl burst model: after seeing a request, len data strobes then
    // one finish pulse. Stray strobes can be injected on either side.
    initial begin
        bit            w_act = 1'b0;
        bit            r_act = 1'b0;
        int            w_cnt = 0;
        int            r_cnt = 0;
        logic [DW-1:0] r_pat = 32'hD000_0000;
        m_wr_data_req = 1'b0; m_wr_finish = 1'b0;
        m_rd_data_valid = 1'b0; m_rd_finish = 1'b0; m_rd_data = '0;
        forever begin
            @(posedge mem_clk);
            #1;
            m_wr_data_req = 1'b0; m_wr_finish = 1'b0;
            m_rd_data_valid = 1'b0; m_rd_finish = 1'b0;
            if (rst) begin
                w_act = 1'b0;
                r_act = 1'b0;
            end else begin
                if (!w_act && m_wr_req) begin
                    w_act = 1'b1;
                    w_cnt = int'(m_wr_len);
                end
                if (w_act) begin
                    if (w_cnt != 0) begin
                        m_wr_data_req = 1'b1;
                        w_cnt--;
                    end else begin
                        m_wr_finish = 1'b1;
                        w_act = 1'b0;
                    end
                end
                if (!r_act && m_rd_req) begin
                    r_act = 1'b1;
                    r_cnt = int'(m_rd_len);
                end
                if (r_act) begin
                    if (r_cnt != 0) begin
                        m_rd_data_valid = 1'b1;
                        r_pat = r_pat + 32'd1;
                        m_rd_data = r_pat;
                        r_cnt--;
                    end else begin
                        m_rd_finish = 1'b1;
                        r_act = 1'b0;
                    end
                end
                if (stray_wr) begin
                    m_wr_data_req = 1'b1;
                    m_wr_finish = 1'b1;
                end
                if (stray_rd) begin
                    m_rd_data_valid = 1'b1;
                    m_rd_finish = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        bit   prev_w = 1'b0;
        bit   prev_r = 1'b0;
        req_t cur_w;
        req_t cur_r;
        req_t e;
        fin_t f;
        cur_w = '{0, '0, '0, 0};
        cur_r = '{1, '0, '0, 0};
        forever begin
            @(negedge mem_clk);
            if (rst) begin
                wr_beats = 0;
                rd_beats = 0;
                prev_w = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (m_wr_req && m_rd_req) begin
                    chk("both_m_req", 64'({m_wr_req, m_rd_req}), 64'b10);
                end
                if (m_wr_req && !prev_w) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_m_wr_req", 64'(m_wr_req), 64'd0);
                    end else begin
                        e = exp_req.pop_front();
                        cur_w = e;
                        chk("grant_dir_wr", 64'(e.rd), 64'd0);
                        chk("m_wr_req_cycle", 64'(cyc), 64'(e.cyc));
                        chk("grant_onehot_wr", 64'(grant), 64'b01);
                    end
                end
                if (m_rd_req && !prev_r) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_m_rd_req", 64'(m_rd_req), 64'd0);
                    end else begin
                        e = exp_req.pop_front();
                        cur_r = e;
                        chk("grant_dir_rd", 64'(e.rd), 64'd1);
                        chk("m_rd_req_cycle", 64'(cyc), 64'(e.cyc));
                        chk("grant_onehot_rd", 64'(grant), 64'b10);
                    end
                end
                if (m_wr_req) begin
                    chk("m_wr_addr", 64'(m_wr_addr), 64'(cur_w.addr));
                    chk("m_wr_len", 64'(m_wr_len), 64'(cur_w.len));
                end
                if (m_rd_req) begin
                    chk("m_rd_addr", 64'(m_rd_addr), 64'(cur_r.addr));
                    chk("m_rd_len", 64'(m_rd_len), 64'(cur_r.len));
                end
                if (wr_data_req) begin
                    wr_beats++;
                    chk("m_wr_data", 64'(m_wr_data), 64'(wr_data));
                end
                if (rd_data_valid) begin
                    rd_beats++;
                    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
                end
                if (wr_finish || rd_finish) begin
                    fin_cnt++;
                    last_fin_cyc = cyc;
                    if (exp_fin.size() == 0) begin
                        chk("unexpected_finish", 64'({wr_finish, rd_finish}), 64'd0);
                    end else begin
                        f = exp_fin.pop_front();
                        chk("finish_dir", 64'({wr_finish, rd_finish}), f.rd ? 64'b01 : 64'b10);
                        chk("finish_beats", 64'(f.rd ? rd_beats : wr_beats), 64'(f.beats));
                        chk("finish_cycle", 64'(cyc), 64'(f.cyc));
                    end
                    if (wr_finish) wr_beats = 0;
                    if (rd_finish) rd_beats = 0;
                end
                prev_w = m_wr_req;
                prev_r = m_rd_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int exp_cyc;
        rst = 1'b1; init_done = 1'b1;
        wr_req = 1'b0; wr_len = '0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_len = '0; rd_addr = '0;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_wr_req", 64'(m_wr_req), 64'd0);
        chk("rst_m_rd_req", 64'(m_rd_req), 64'd0);
        chk("rst_m_wr_addr", 64'(m_wr_addr), 64'd0);
        chk("rst_m_rd_len", 64'(m_rd_len), 64'd0);
        chk("rst_wr_finish", 64'(wr_finish), 64'd0);
        chk("rst_rd_finish", 64'(rd_finish), 64'd0);

        // Write only, len 64 at 0x100, with stray read strobes mid-burst
        n0 = fin_cnt;
        wr_len = 10'd64; wr_addr = 25'h100; wr_data = 32'hCAFE_0001; wr_req = 1'b1;
        push_req(1'b0, 25'h100, 10'd64, cyc + 1);
        push_fin(1'b0, 64, cyc + 65);
        wait_beats(1'b0, 10, "wr_beats10");
        chk("wr_busy_mid", 64'(busy), 64'd1);
        chk("wr_grant_mid", 64'(grant), 64'b01);
        stray_rd = 1'b1;
        step(2);
        stray_rd = 1'b0;
        wait_fin(n0, "wr64_finish");
        wr_req = 1'b0;
        chk("wr_busy_after", 64'(busy), 64'd0);
        chk("wr_grant_after", 64'(grant), 64'd0);
        chk("wr_m_req_after", 64'(m_wr_req), 64'd0);
        step(3);

        // Zero-length write: finish one cycle after selection, no m_wr_req
        n0 = fin_cnt;
        wr_len = 10'd0; wr_addr = 25'h40; wr_req = 1'b1;
        push_fin(1'b0, 0, cyc + 1);
        wait_fin(n0, "wr0_finish");
        wr_req = 1'b0;
        step(3);

        // init_done low for 100 cycles with both requests held
        init_done = 1'b0;
        wr_len = 10'd4; wr_addr = 25'h300; wr_data = 32'h1234_5678;
        rd_len = 10'd8; rd_addr = 25'h2000;
        wr_req = 1'b1; rd_req = 1'b1;
        step(100);
        chk("nodone_m_wr_req", 64'(m_wr_req), 64'd0);
        chk("nodone_m_rd_req", 64'(m_rd_req), 64'd0);
        chk("nodone_busy", 64'(busy), 64'd0);
        n0 = fin_cnt;
        init_done = 1'b1;
        push_req(1'b1, 25'h2000, 10'd8, cyc + 1);
        push_fin(1'b1, 8, cyc + 9);
        wait_beats(1'b1, 3, "rd_beats3");
        stray_wr = 1'b1;
        step(1);
        stray_wr = 1'b0;
        wait_fin(n0, "rd8_finish");
        rd_req = 1'b0;
        n0 = fin_cnt;
        push_req(1'b0, 25'h300, 10'd4, last_fin_cyc + 3);
        push_fin(1'b0, 4, last_fin_cyc + 7);
        wait_fin(n0, "wr4_finish");
        wr_req = 1'b0;
        step(3);

        // Both requesting continuously after reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        wr_len = 10'd16; wr_addr = 25'h4000; rd_len = 10'd16; rd_addr = 25'h8000;
        n0 = fin_cnt;
        wr_req = 1'b1; rd_req = 1'b1;
        exp_cyc = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            bit d;
            if (i == 4) begin
                d = 1'b0;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                d = (i % 2) == 1;
`else
                d = 1'b1;
`endif
            end
            push_req(d, d ? 25'h8000 : 25'h4000, 10'd16, exp_cyc);
            push_fin(d, 16, exp_cyc + 16);
            wait_fin(n0, "both_finish");
            n0 = fin_cnt;
            if (i == 3) rd_req = 1'b0;
            exp_cyc = last_fin_cyc + 3;
        end
        wr_req = 1'b0;
        step(3);

        // Reset in the middle of a 32-beat read
        n0 = fin_cnt;
        rd_len = 10'd32; rd_addr = 25'h1234; rd_req = 1'b1;
        push_req(1'b1, 25'h1234, 10'd32, cyc + 1);
        push_fin(1'b1, 32, cyc + 33);
        wait_beats(1'b1, 5, "rd_beats5");
        rst = 1'b1;
        rd_req = 1'b0;
        exp_fin.delete();
        step(1);
        chk("mrst_grant", 64'(grant), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_m_rd_req", 64'(m_rd_req), 64'd0);
        chk("mrst_m_rd_len", 64'(m_rd_len), 64'd0);
        chk("mrst_m_rd_addr", 64'(m_rd_addr), 64'd0);
        chk("mrst_rd_finish", 64'(rd_finish), 64'd0);
        rst = 1'b0;
        stray_rd = 1'b1; stray_wr = 1'b1;
        step(1);
        chk("stray_rd_data_valid", 64'(rd_data_valid), 64'd0);
        chk("stray_rd_finish", 64'(rd_finish), 64'd0);
        chk("stray_wr_data_req", 64'(wr_data_req), 64'd0);
        chk("stray_wr_finish", 64'(wr_finish), 64'd0);
        stray_rd = 1'b0; stray_wr = 1'b0;
        step(3);
        chk("no_finish_after_rst", 64'(fin_cnt), 64'(n0));
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("fin_queue_empty", 64'(exp_fin.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
